io_ready_check: RTL

- Sits directly downstream of the address offset stage.
- Takes each thread's translated operand address and decides whether it targets a memory-mapped read I/O port.
- Checks that port's data-available flag and produces IO_Ready for the current instruction.
- Issues a one-cycle consume pulse to the port when the access proceeds; a pending mask prevents back-to-back threads double-reading a port whose flag has not yet dropped.

---
 rtl/io_ready_check_pkg.sv | 20 ++
 rtl/io_port_pending.sv | 41 ++++
 rtl/io_ready_check.sv | 120 ++++++++++++
 3 files changed

// File: rtl/io_ready_check_pkg.sv
// Shared constants and the stage-1 record for the I/O ready check pipeline.
package io_ready_check_pkg;

  localparam int unsigned ADDR_WIDTH         = 10;
  localparam int unsigned PORT_BASE          = 1016;
  localparam int unsigned PORT_COUNT         = 8;
  localparam int unsigned PORT_COUNT_WIDTH   = 3;
  localparam int unsigned THREAD_COUNT       = 8;
  localparam int unsigned THREAD_COUNT_WIDTH = 3;
  localparam int unsigned PENDING_CYCLES     = 2;

  // Decoded operand as captured in stage 1, tagged with the owning thread.
  typedef struct packed {
    logic                          hit;
    logic [PORT_COUNT_WIDTH-1:0]   port_idx;
    logic                          cancel;
    logic [THREAD_COUNT_WIDTH-1:0] tag;
  } stage1_t;

endpackage

// File: rtl/io_port_pending.sv
// Per-port pending countdown: a lane is busy for Cycles cycles after it is loaded.
module io_port_pending #(
  parameter int unsigned Lanes  = 8,
  parameter int unsigned Cycles = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Lanes-1:0] load_i,
  output logic [Lanes-1:0] busy_o
);

  localparam int unsigned CntW = $clog2(Cycles + 1);

  logic [CntW-1:0] cnt_q [Lanes];
  logic [CntW-1:0] cnt_d [Lanes];

  // Load on consume, otherwise count down and hold at zero.
  always_comb begin
    for (int i = 0; i < int'(Lanes); i++) begin
      cnt_d[i]  = cnt_q[i];
      busy_o[i] = (cnt_q[i] != '0);
      if (load_i[i]) begin
        cnt_d[i] = CntW'(Cycles);
      end else if (cnt_q[i] != '0) begin
        cnt_d[i] = cnt_q[i] - CntW'(1);
      end
    end
  end

  // Counter registers, synchronous active-low clear.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < int'(Lanes); i++) begin
      if (!rst_ni) begin
        cnt_q[i] <= '0;
      end else begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule

// File: rtl/io_ready_check.sv
// I/O ready check: decodes translated operand addresses against the read-port window,
// gates on port data-available and pending masks, and issues one-cycle consume pulses.
// Optional per-thread stall counters are built when IO_READY_STALL_COUNT_EN is defined.
module io_ready_check
  import io_ready_check_pkg::*;
(
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [ADDR_WIDTH-1:0]         offset_addr,
  input  logic                          addr_used,
  input  logic                          Cancel_current,
  input  logic [PORT_COUNT-1:0]         port_ready,
`ifdef IO_READY_STALL_COUNT_EN
  output logic [7:0]                    stall_count,
`endif
  output logic                          IO_Ready,
  output logic [PORT_COUNT-1:0]         port_read,
  output logic [THREAD_COUNT_WIDTH-1:0] thread_id
);

  logic [THREAD_COUNT_WIDTH-1:0] thr_q, thr_d;
  stage1_t                       s1_q, s1_d;
  logic                          io_ready_q, io_ready_d;
  logic [PORT_COUNT-1:0]         port_read_q, port_read_d;
  logic [THREAD_COUNT_WIDTH-1:0] thread_id_q, thread_id_d;
  logic [PORT_COUNT-1:0]         pend_busy;
  logic [ADDR_WIDTH:0]           rel;
  logic                          avail;

  // Stage 1: window decode; offsets below the base wrap to large values and miss.
  always_comb begin
    rel         = {1'b0, offset_addr} - (ADDR_WIDTH + 1)'(PORT_BASE);
    s1_d.hit    = addr_used & (rel < (ADDR_WIDTH + 1)'(PORT_COUNT));
    s1_d.port_idx = rel[PORT_COUNT_WIDTH-1:0];
    s1_d.cancel = Cancel_current;
    s1_d.tag    = thr_q;
    thr_d = (thr_q == THREAD_COUNT_WIDTH'(THREAD_COUNT - 1)) ? '0
                                                             : thr_q + THREAD_COUNT_WIDTH'(1);
  end

  // Stage 2: availability, ready and one-hot consume pulse.
  always_comb begin
    avail       = port_ready[s1_q.port_idx] & ~pend_busy[s1_q.port_idx];
    io_ready_d  = ~s1_q.hit | avail;
    port_read_d = '0;
    if (s1_q.hit && avail && !s1_q.cancel) begin
      port_read_d[s1_q.port_idx] = 1'b1;
    end
    thread_id_d = s1_q.tag;
  end

  // Pending mask is loaded on the same edge the consume pulse is registered.
  io_port_pending #(
    .Lanes  (PORT_COUNT),
    .Cycles (PENDING_CYCLES)
  ) u_pending (
    .clk_i  (clock),
    .rst_ni (reset_n),
    .load_i (port_read_d),
    .busy_o (pend_busy)
  );

  // Pipeline and output registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      thr_q       <= '0;
      s1_q        <= '0;
      io_ready_q  <= 1'b0;
      port_read_q <= '0;
      thread_id_q <= '0;
    end else begin
      thr_q       <= thr_d;
      s1_q        <= s1_d;
      io_ready_q  <= io_ready_d;
      port_read_q <= port_read_d;
      thread_id_q <= thread_id_d;
    end
  end

  assign IO_Ready  = io_ready_q;
  assign port_read = port_read_q;
  assign thread_id = thread_id_q;

`ifdef IO_READY_STALL_COUNT_EN
  logic [7:0] stall_q [THREAD_COUNT];
  logic [7:0] stall_d [THREAD_COUNT];
  logic [7:0] stall_count_q, stall_count_d;

  // Saturating per-thread stall count; cleared when the thread's I/O access proceeds.
  always_comb begin
    stall_d = stall_q;
    if (s1_q.hit && !avail && !s1_q.cancel) begin
      if (stall_q[s1_q.tag] != 8'hFF) begin
        stall_d[s1_q.tag] = stall_q[s1_q.tag] + 8'd1;
      end
    end else if (s1_q.hit && avail) begin
      stall_d[s1_q.tag] = 8'd0;
    end
    stall_count_d = stall_d[s1_q.tag];
  end

  // Stall counter registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(THREAD_COUNT); i++) begin
        stall_q[i] <= 8'd0;
      end
      stall_count_q <= 8'd0;
    end else begin
      for (int i = 0; i < int'(THREAD_COUNT); i++) begin
        stall_q[i] <= stall_d[i];
      end
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;
`endif

endmodule
